// File: rtl/tick_timer_arbiter_if.sv
// rtl/tick_timer_arbiter_if.sv - requester-side bundle for the shared tick timer
// Optional pause input is present only when TIMER_PAUSE_EN is defined.
interface tick_timer_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DUR_W   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*DUR_W-1:0] dur;
`ifdef TIMER_PAUSE_EN
    logic                     pause;
`endif
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [DUR_W-1:0]         remaining;
    logic                     tick;

    modport master (
        output req, dur,
`ifdef TIMER_PAUSE_EN
        output pause,
`endif
        input  grant, done, busy, remaining, tick
    );

    modport slave (
        input  req, dur,
`ifdef TIMER_PAUSE_EN
        input  pause,
`endif
        output grant, done, busy, remaining, tick
    );
endinterface

// File: rtl/tick_timer_arbiter.sv
// rtl/tick_timer_arbiter.sv - round-robin shared prescaled countdown timer
// Optional feature macro: TIMER_PAUSE_EN (freezes the running countdown).
module tick_timer_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DUR_W    = 8,
    parameter int PRESCALE = 1000
) (
    input  logic               clk,
    input  logic               reset,
    tick_timer_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   owner, last, sel_idx, cand;
    logic               sel_valid;
    logic [DUR_W-1:0]   rem, dur_sel;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] owner_oh;
    logic               tick_int, paused, owner_req;

`ifdef TIMER_PAUSE_EN
    assign paused = bus.pause;
`else
    assign paused = 1'b0;
`endif

    // Search starts just past the last served index so every requester gets a turn.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = last;
        cand      = last;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last) + i) % NUM_REQ);
            if (!sel_valid && bus.req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        dur_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IDX_W'(i)) dur_sel = bus.dur[i*DUR_W +: DUR_W];
        end
    end

    assign owner_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
    assign owner_req = bus.req[owner];
    assign tick_int  = (state == RUN) && (cnt == CNT_W'(PRESCALE-1)) && !paused;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.grant     = '0;
        bus.done      = '0;
        bus.busy      = (state != IDLE);
        bus.remaining = '0;
        bus.tick      = tick_int;
        case (state)
            IDLE: begin
                if (sel_valid) state_nxt = (dur_sel == '0) ? DONE : RUN;
            end
            RUN: begin
                bus.grant     = owner_oh;
                bus.remaining = rem;
                // Withdrawal beats a final tick in the same cycle: no done for an abandoned request.
                if (!owner_req)                          state_nxt = IDLE;
                else if (tick_int && rem == DUR_W'(1))   state_nxt = DONE;
            end
            DONE: begin
                bus.done  = owner_oh;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= '0;
            last  <= IDX_W'(NUM_REQ-1);
            rem   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (sel_valid) begin
                        owner <= sel_idx;
                        rem   <= dur_sel;
                    end
                end
                RUN: begin
                    if (!owner_req) begin
                        last <= owner;
                        rem  <= '0;
                        cnt  <= '0;
                    end else if (!paused) begin
                        if (tick_int) begin
                            cnt <= '0;
                            if (rem != '0) rem <= rem - DUR_W'(1);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    last <= owner;
                    rem  <= '0;
                    cnt  <= '0;
                end
                default: begin
                    rem <= '0;
                    cnt <= '0;
                end
            endcase
        end
    end
endmodule
